// File: rtl/fifo_core.sv
// Single-clock byte FIFO with registered read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_core #(
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned ADDR_WIDTH          = 3,
  parameter int unsigned ALMOST_FULL_THRESH  = 6,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);

  // The extra MSB on each pointer distinguishes full from empty when the
  // address bits are equal; the difference is the occupancy directly.
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;

  assign count        = wptr - rptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance uses the flags as they stand before the edge, so a write at
  // full is refused even when a read frees a slot in the same cycle.
  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  // NOTE: the storage array has no reset; its contents are only meaningful
  // between the pointers, and leaving it out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the pointers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        data_out <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr     <= rptr + 1'b1;
      end
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_core.sv
// Self-checking bench for fifo_core: directed vector table, hand-written
// reset/wrap sequences, and randomized traffic against a queue-based model.
module tb_fifo_core;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  fifo_core #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3),
    .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue plus the registered output and sticky flags.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_unf;

  typedef struct {
    bit         w;
    bit         r;
    logic [7:0] d;
    int         cnt;
    logic [7:0] dout;
    bit         ovf;
    bit         unf;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit w, bit r, logic [7:0] d, int cnt,
                              logic [7:0] dout, bit ovf, bit unf);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  function automatic void model_step(bit w, bit r, logic [7:0] d);
    int sz = mq.size();
    if (r && sz > 0) m_dout = mq.pop_front();
    else if (r)      m_unf  = 1'b1;
    if (w && sz < DEPTH) mq.push_back(d);
    else if (w)          m_ovf = 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_cnt, input logic [7:0] e_dout,
                           input bit e_ovf, input bit e_unf);
    check($sformatf("%s.count", tag),        32'(count),        32'(e_cnt));
    check($sformatf("%s.data_out", tag),     32'(data_out),     32'(e_dout));
    check($sformatf("%s.full", tag),         32'(full),         32'(e_cnt == DEPTH));
    check($sformatf("%s.empty", tag),        32'(empty),        32'(e_cnt == 0));
    check($sformatf("%s.almost_full", tag),  32'(almost_full),  32'(e_cnt >= AF));
    check($sformatf("%s.almost_empty", tag), 32'(almost_empty), 32'(e_cnt <= AE));
    check($sformatf("%s.overflow", tag),     32'(overflow),     32'(e_ovf));
    check($sformatf("%s.underflow", tag),    32'(underflow),    32'(e_unf));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    w_en = w; r_en = r; data_in = d;
    @(posedge clk);
    #1;
    model_step(w, r, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    rst_n = 1'b0;
    #30;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int written, reads, budget;
    int pw, pr;
    bit w, r;

    // Directed table: order, full/overflow, underflow, simultaneous R/W.
    for (int i = 0; i < 6; i++) add(1, 0, 8'(i), i + 1, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 8'h00, 5 - i, 8'(i), 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 8'(8'hA0 + i), i + 1, 8'h05, 0, 0);
    add(1, 0, 8'hFF, 8, 8'h05, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 8'h00, 7 - i, 8'(8'hA0 + i), 1, 0);
    add(0, 1, 8'h00, 0, 8'hA7, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 8'(8'h10 + i), i + 1, 8'hA7, 1, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 8'(8'h13 + i), 3, 8'(8'h10 + i), 1, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 8'(8'h17 + i), 4 + i, 8'h13, 1, 1);
    add(1, 1, 8'hFF, 7, 8'h14, 1, 1);
    for (int i = 0; i < 7; i++) add(0, 1, 8'h00, 6 - i, 8'(8'h15 + i), 1, 1);
    add(1, 1, 8'h55, 1, 8'h1B, 1, 1);
    add(0, 1, 8'h00, 0, 8'h55, 1, 1);

    // Reset held 30 ns, then check the idle state.
    model_reset();
    rst_n = 1'b0;
    #30;
    rst_n = 1'b1;
    #1;
    check_all("reset", 0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].unf);
    end

    // Stream 20 words with occupancy kept in 1..8 so both pointers wrap.
    do_reset();
    written = 0; reads = 0; budget = 0;
    while ((written < 20 || mq.size() > 0) && budget < 400) begin
      w = (written < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      r = (mq.size() > 1 || written == 20) && (mq.size() > 0) && ($urandom_range(0, 3) != 0);
      if (w) written++;
      if (r) reads++;
      step(w, r, 8'(8'h30 + (written - 1)));
      check_all($sformatf("wrap%0d", budget), mq.size(), m_dout, m_ovf, m_unf);
      budget++;
    end
    check("wrap.reads", 32'(reads), 32'd20);
    check("wrap.last_word", 32'(data_out), 32'h43);

    // Asynchronous reset mid-stream: state clears without a clock edge.
    step(1, 0, 8'h61);
    step(1, 0, 8'h62);
    step(1, 1, 8'h63);
    check_all("pre_rst", 2, 8'h61, 0, 0);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 8'h00, 0, 0);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all("post_rst", 0, 8'h00, 0, 0);

    // Randomized traffic with changing read/write bias against the model.
    for (int blk = 0; blk < 6; blk++) begin
      pw = $urandom_range(1, 9);
      pr = $urandom_range(1, 9);
      for (int c = 0; c < 100; c++) begin
        w = ($urandom_range(0, 9) < pw);
        r = ($urandom_range(0, 9) < pr);
        step(w, r, 8'($urandom));
        check_all($sformatf("rnd%0d_%0d", blk, c), mq.size(), m_dout, m_ovf, m_unf);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_core.md
Name: fifo_core

Overview:
Single-clock, synchronous-write/synchronous-read byte FIFO used as a rate buffer between a producer and consumer in the same clock domain. Stores up to 2^ADDR_WIDTH words. Reports full/empty, occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Read data is registered (one-cycle read latency).

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 3, log2 of depth (DEPTH = 8)
ALMOST_FULL_THRESH, 6, almost_full asserts when count >= this value
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when count <= this value

Ports:
clk  input  1  single FIFO clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
w_en  input  1  write request
r_en  input  1  read request
data_in  input  DATA_WIDTH  write data, sampled on rising clk when write accepted
data_out  output  DATA_WIDTH  registered read data
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= ALMOST_FULL_THRESH
almost_empty  output  1  count <= ALMOST_EMPTY_THRESH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate, independent of clk): write/read pointers = 0, data_out = 0, overflow = underflow = 0; hence count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0. Memory contents are not cleared.
- Pointers are ADDR_WIDTH+1 bits (extra wrap bit). Memory address = low ADDR_WIDTH bits.
- count = wptr - rptr, modulo 2^(ADDR_WIDTH+1). full/empty/almost flags are combinational from the registered pointers, so they reflect the state after the most recent edge.
- Write accepted iff w_en=1 and full=0 (flag value before the edge): mem[wptr] <= data_in, wptr <= wptr+1.
- Read accepted iff r_en=1 and empty=0 (flag value before the edge): data_out <= mem[rptr], rptr <= rptr+1. Data is valid on data_out after the same rising edge; there is no combinational path from r_en to data_out.
- data_out holds its last value when no read is accepted, including while empty.
- Simultaneous w_en and r_en with 0 < count < DEPTH: both are accepted and count is unchanged.
- Simultaneous w_en and r_en at empty: only the write is accepted, count goes 0->1, data_out unchanged, underflow set.
- Simultaneous w_en and r_en at full: only the read is accepted, count goes DEPTH->DEPTH-1, overflow set. A write is never accepted while full, even with a concurrent read.
- Rejected write: memory and wptr unchanged; overflow <= 1.
- Rejected read: rptr and data_out unchanged; underflow <= 1.
- overflow and underflow are cleared only by reset.
- Pointer wrap-around: after 2^(ADDR_WIDTH+1) accepted operations a pointer returns to 0. FIFO ordering and flag behaviour are unaffected by wrap.
- Reset asserted mid-operation: state returns to reset values immediately. An operation in the same cycle as reset deassertion is governed by the synchronous rules on the next rising edge.

Test Plan:
1. Reset check: hold rst_n=0 for 30 ns, then release -> empty=1, full=0, count=0, data_out=0, overflow=0, underflow=0.
2. Write/read order: write 0,1,2,3,4,5 on consecutive cycles -> count=6, almost_full=1, full=0. Then read 6 times -> data_out = 0,1,2,3,4,5, each valid one cycle after its read edge; afterwards empty=1, count=0.
3. Full/overflow: write 8 words 0xA0..0xA7 -> full=1, count=8. A 9th write of 0xFF is dropped and overflow=1. Read 8 times -> 0xA0..0xA7 in order, then empty=1.
4. Underflow: read while empty -> data_out holds its last value, count stays 0, underflow=1 until reset.
5. Simultaneous read/write: with count=3, assert w_en and r_en for 4 cycles -> count stays 3 and output order is preserved. At count=8 with both asserted -> one read accepted, count=7, overflow=1.
6. Wrap-around: stream 20 words through while keeping occupancy between 1 and 8 -> all 20 words read back in order; mid-stream reset -> count=0 and empty=1 immediately.
